// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state type, requester indices and id sizing for the bus arbiter
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    TURNAROUND
  } arb_state_t;

  localparam int REQ_CTRL = 0;
  localparam int REQ_IO   = 1;
  localparam int REQ_DBG  = 2;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant bundle between bus masters and the arbiter
interface bus_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import bus_arb_pkg::*;

  localparam int ID_W = id_width(NUM_REQ);

  logic               enabled;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] lock;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] grant;
  logic               bus_busy;
  logic [ID_W-1:0]    owner_id;
  logic               timeout_err;
  logic [ID_W-1:0]    timeout_id;

  modport master (
    output enabled, req, lock, done,
    input  grant, bus_busy, owner_id, timeout_err, timeout_id
  );

  modport slave (
    input  enabled, req, lock, done,
    output grant, bus_busy, owner_id, timeout_err, timeout_id
  );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - circular priority encoder with optional fixed priority for the control unit
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               prio_en,
  output logic               valid,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    if (prio_en && req[REQ_CTRL]) begin
      valid  = 1'b1;
      winner = ID_W'(REQ_CTRL);
    end else begin
      // the search starts one past the last winner, so rr_ptr itself is tried last
      for (int i = 1; i <= NUM_REQ; i++) begin
        idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
        if (!valid && req[idx]) begin
          valid  = 1'b1;
          winner = idx;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - single-owner bus arbiter with turnaround gap and hold timeout
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int MAX_HOLD      = 8,
  parameter bit CTRL_PRIORITY = 1'b1
) (
  input  logic          ctrl_clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  localparam int         ID_W       = id_width(NUM_REQ);
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  arb_state_t      state;
  logic [7:0]      hold_cnt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick_id;
  logic            pick_valid;
  logic            owner_done;
  logic            owner_drop;
  logic            owner_expire;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .prio_en(CTRL_PRIORITY),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  assign owner_done   = bus.done[bus.owner_id];
  assign owner_drop   = !bus.req[bus.owner_id];
  assign owner_expire = (hold_cnt >= HOLD_LIMIT) && !bus.lock[bus.owner_id];

  // hold_cnt counts grant cycles including the current one, so it is 1 on the first owned cycle
  always_ff @(posedge ctrl_clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      hold_cnt        <= '0;
      rr_ptr          <= ID_W'(NUM_REQ - 1);
      bus.grant       <= '0;
      bus.bus_busy    <= 1'b0;
      bus.owner_id    <= '0;
      bus.timeout_err <= 1'b0;
      bus.timeout_id  <= '0;
    end else begin
      bus.timeout_err <= 1'b0;
      case (state)
        IDLE, TURNAROUND: begin
          if (bus.enabled && pick_valid) begin
            state        <= OWNED;
            hold_cnt     <= 8'd1;
            rr_ptr       <= pick_id;
            bus.grant    <= NUM_REQ'(1) << pick_id;
            bus.bus_busy <= 1'b1;
            bus.owner_id <= pick_id;
          end else begin
            state <= IDLE;
          end
        end
        OWNED: begin
          if (owner_done || owner_drop || owner_expire) begin
            state        <= TURNAROUND;
            bus.grant    <= '0;
            bus.bus_busy <= 1'b0;
            // a voluntary release in the same cycle wins over the forced one
            if (!owner_done && !owner_drop) begin
              bus.timeout_err <= 1'b1;
              bus.timeout_id  <= bus.owner_id;
            end
          end else if (hold_cnt < HOLD_LIMIT) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - bench for bus_arbiter, priority and plain round-robin instances side by side
module tb_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         ctrl_clk = 1'b0;
  logic         reset    = 1'b0;
  logic         enabled  = 1'b1;
  logic [N-1:0] req      = '0;
  logic [N-1:0] lock     = '0;
  logic [N-1:0] done     = '0;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter_if #(.NUM_REQ(N)) bus_p ();
  bus_arbiter_if #(.NUM_REQ(N)) bus_r ();

  assign bus_p.enabled = enabled;
  assign bus_p.req     = req;
  assign bus_p.lock    = lock;
  assign bus_p.done    = done;
  assign bus_r.enabled = enabled;
  assign bus_r.req     = req;
  assign bus_r.lock    = lock;
  assign bus_r.done    = done;

  bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAX_HOLD), .CTRL_PRIORITY(1'b1)) dut_prio (
    .ctrl_clk(ctrl_clk),
    .reset   (reset),
    .bus     (bus_p)
  );

  bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAX_HOLD), .CTRL_PRIORITY(1'b0)) dut_rr (
    .ctrl_clk(ctrl_clk),
    .reset   (reset),
    .bus     (bus_r)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  logic [N-1:0] act_grant [2];
  logic         act_busy  [2];
  logic [1:0]   act_oid   [2];
  logic         act_terr  [2];
  logic [1:0]   act_tid   [2];

  assign act_grant[0] = bus_p.grant;
  assign act_grant[1] = bus_r.grant;
  assign act_busy[0]  = bus_p.bus_busy;
  assign act_busy[1]  = bus_r.bus_busy;
  assign act_oid[0]   = bus_p.owner_id;
  assign act_oid[1]   = bus_r.owner_id;
  assign act_terr[0]  = bus_p.timeout_err;
  assign act_terr[1]  = bus_r.timeout_err;
  assign act_tid[0]   = bus_p.timeout_id;
  assign act_tid[1]   = bus_r.timeout_id;

  // model: instance 0 has control priority, instance 1 is plain round-robin; owner -1 means nobody
  int m_own  [2] = '{-1, -1};
  int m_last [2] = '{0, 0};
  int m_held [2] = '{0, 0};
  int m_ptr  [2] = '{N - 1, N - 1};
  int m_tid  [2] = '{0, 0};
  bit m_terr [2] = '{1'b0, 1'b0};

  function automatic int pick(input int ptr, input bit prio, input logic [N-1:0] r);
    if (prio && r[0]) return 0;
    for (int i = 1; i <= N; i++)
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  always @(posedge ctrl_clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_own[k]  = -1;
        m_last[k] = 0;
        m_held[k] = 0;
        m_ptr[k]  = N - 1;
        m_tid[k]  = 0;
        m_terr[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int o;
        int w;
        o = m_own[k];
        m_terr[k] = 1'b0;
        if (o >= 0) begin
          if (done[o] || !req[o]) begin
            m_own[k] = -1;
          end else if (m_held[k] >= MAX_HOLD && !lock[o]) begin
            m_own[k]  = -1;
            m_terr[k] = 1'b1;
            m_tid[k]  = o;
          end else begin
            m_held[k] = m_held[k] + 1;
          end
        end else if (enabled) begin
          w = pick(m_ptr[k], (k == 0), req);
          if (w >= 0) begin
            m_own[k]  = w;
            m_held[k] = 1;
            m_ptr[k]  = w;
            m_last[k] = w;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [N-1:0] eg;
    @(negedge ctrl_clk);
    for (int k = 0; k < 2; k++) begin
      eg = (m_own[k] >= 0) ? N'(1) << m_own[k] : '0;
      check($sformatf("model_grant[%0d]", k), 32'(act_grant[k]), 32'(eg));
      check($sformatf("model_busy[%0d]", k),  32'(act_busy[k]),  32'(m_own[k] >= 0));
      check($sformatf("model_owner[%0d]", k), 32'(act_oid[k]),   32'(m_last[k]));
      check($sformatf("model_terr[%0d]", k),  32'(act_terr[k]),  32'(m_terr[k]));
      check($sformatf("model_tid[%0d]", k),   32'(act_tid[k]),   32'(m_tid[k]));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  logic [N-1:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    tick();
    tick();
    check("reset_grant", 32'(bus_p.grant), 32'h0);
    check("reset_busy",  32'(bus_p.bus_busy), 32'h0);
    check("reset_owner", 32'(bus_p.owner_id), 32'h0);
    check("reset_terr",  32'(bus_p.timeout_err), 32'h0);
    check("reset_tid",   32'(bus_p.timeout_id), 32'h0);
    reset = 1'b1;

    // first grant goes to the lowest set request, then turnaround hands over to 2
    req = 4'b0110;
    tick();
    check("t1_grant",    32'(bus_p.grant), 32'h2);
    check("t1_owner",    32'(bus_p.owner_id), 32'h1);
    check("t1_rr_grant", 32'(bus_r.grant), 32'h2);
    done = 4'b0010;
    tick();
    done = '0;
    check("t1_gap", 32'(bus_p.grant), 32'h0);
    tick();
    check("t1_next",    32'(bus_p.grant), 32'h4);
    check("t1_rr_next", 32'(bus_r.grant), 32'h4);
    req = '0;
    tick();
    tick();

    // all requesting, each owner releases after two cycles
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("t2_prio_%0d", g), 32'(bus_p.grant), 32'h1);
      check($sformatf("t2_rr_%0d", g),   32'(bus_r.grant), 32'(exp_rr[g]));
      tick();
      done = 4'b1111;
      tick();
      done = '0;
      check($sformatf("t2_gap_%0d", g), 32'(bus_p.grant | bus_r.grant), 32'h0);
    end
    req = '0;
    tick();
    tick();

    // unlocked hold times out after MAX_HOLD cycles
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= MAX_HOLD; c++) begin
      tick();
      check($sformatf("t3_hold_%0d", c), 32'(bus_p.grant), 32'h4);
      check($sformatf("t3_noterr_%0d", c), 32'(bus_p.timeout_err), 32'h0);
    end
    tick();
    check("t3_release", 32'(bus_p.grant), 32'h0);
    check("t3_terr",    32'(bus_p.timeout_err), 32'h1);
    check("t3_tid",     32'(bus_p.timeout_id), 32'h2);
    check("t3_rr_terr", 32'(bus_r.timeout_err), 32'h1);
    tick();
    check("t3_regrant",   32'(bus_p.grant), 32'h4);
    check("t3_terr_once", 32'(bus_p.timeout_err), 32'h0);
    lock = 4'b0100;
    repeat (20) tick();
    check("t3_locked_grant", 32'(bus_p.grant), 32'h4);
    check("t3_locked_terr",  32'(bus_p.timeout_err), 32'h0);

    // done coinciding with the timeout edge, plus a stray done from a non-owner
    req  = '0;
    lock = '0;
    tick();
    check("t4_drop",      32'(bus_p.grant), 32'h0);
    check("t4_drop_terr", 32'(bus_p.timeout_err), 32'h0);
    req = 4'b0100;
    for (int c = 1; c <= MAX_HOLD; c++) begin
      tick();
      check($sformatf("t4_hold_%0d", c), 32'(bus_p.grant), 32'h4);
      if (c == 3) done = 4'b1000;
      if (c == 4) done = '0;
      if (c == MAX_HOLD) done = 4'b0100;
    end
    tick();
    done = '0;
    check("t4_release", 32'(bus_p.grant), 32'h0);
    check("t4_no_terr", 32'(bus_p.timeout_err), 32'h0);
    check("t4_tid_held", 32'(bus_p.timeout_id), 32'h2);
    req = '0;
    tick();

    // asynchronous reset between edges
    req = 4'b0010;
    tick();
    check("t5_grant", 32'(bus_p.grant), 32'h2);
    #2 reset = 1'b0;
    #1;
    check("t5_async_grant",    32'(bus_p.grant), 32'h0);
    check("t5_async_busy",     32'(bus_p.bus_busy), 32'h0);
    check("t5_async_rr_grant", 32'(bus_r.grant), 32'h0);
    req = 4'b1000;
    tick();
    reset = 1'b1;
    tick();
    check("t5_after_grant", 32'(bus_p.grant), 32'h8);
    check("t5_after_owner", 32'(bus_p.owner_id), 32'h3);
    check("t5_after_rr",    32'(bus_r.grant), 32'h8);

    // enable gating
    req = '0;
    tick();
    tick();
    enabled = 1'b0;
    req = 4'b0001;
    tick();
    tick();
    tick();
    check("t6_disabled", 32'(bus_p.grant | bus_r.grant), 32'h0);
    enabled = 1'b1;
    req = 4'b0010;
    tick();
    check("t6_grant", 32'(bus_p.grant), 32'h2);
    enabled = 1'b0;
    tick();
    tick();
    check("t6_keeps", 32'(bus_p.grant), 32'h2);
    done = 4'b0010;
    tick();
    done = '0;
    check("t6_release", 32'(bus_p.grant), 32'h0);
    tick();
    tick();
    check("t6_stays_idle", 32'(bus_p.grant), 32'h0);
    check("t6_idle_busy",  32'(bus_p.bus_busy), 32'h0);
    check("t6_last_owner", 32'(bus_p.owner_id), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbitrates ownership of the shared read/data/write bus triple between up to `NUM_REQ` bus masters: the control unit (requester 0) plus I/O and debug masters. Exactly one master may drive the buses at a time. A mandatory one-cycle turnaround with no owner separates consecutive owners, so tri-state drivers never overlap. The block sits beside the control unit on `ctrl_clk` and gates each master's `*_out_en` via its grant line.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8; index 0 is the control unit.
- `MAX_HOLD`, 8: cycles an unlocked owner may hold the buses before forced release, 1..255.
- `CTRL_PRIORITY`, 1: when 1, requester 0 beats round-robin order; when 0, it takes part in plain round-robin.

Ports (one clock; reset is asynchronous and active-low):
- `ctrl_clk`  input  1  sole clock, rising-edge.
- `reset`  input  1  asynchronous, active-low; 0 = in reset.
- `enabled`  input  1  when 0, no new grants are issued; a current owner keeps its grant until it releases.
- `req`  input  NUM_REQ  level request per master.
- `lock`  input  NUM_REQ  owner asserts to suppress the `MAX_HOLD` timeout (multi-word transfers).
- `done`  input  NUM_REQ  one-cycle pulse from the owner to release.
- `grant`  output  NUM_REQ  one-hot or zero; registered.
- `bus_busy`  output  1  high while any grant is asserted.
- `owner_id`  output  clog2(NUM_REQ)  index of current owner; holds last owner when idle.
- `timeout_err`  output  1  one-cycle pulse on forced release.
- `timeout_id`  output  clog2(NUM_REQ)  owner that timed out; held until the next timeout.

## Operation
- States: IDLE, OWNED, TURNAROUND.
- IDLE: if `enabled` and `req` is nonzero, pick a winner, register its grant, go to OWNED. Otherwise stay.
- Pick rule:
  - If `CTRL_PRIORITY` and `req[0]`, the winner is 0.
  - Otherwise, search circularly from `(rr_ptr+1) mod NUM_REQ` for the first set `req` bit.
  - `rr_ptr` is updated to the winner on each grant.
- OWNED: the hold counter increments each cycle, saturating at `MAX_HOLD`. Leave for TURNAROUND with all grants 0 on the first of:
  - `done[owner]`;
  - `req[owner]` falling to 0;
  - counter reaching `MAX_HOLD` with `lock[owner]` low. This also pulses `timeout_err` and loads `timeout_id`.
- `done` or `lock` from a non-owner is ignored. If `lock[owner]` is high, the counter saturates and no timeout fires.
- TURNAROUND: all grants 0 for exactly one cycle. The pick rule is evaluated in this cycle. If there is a winner and `enabled`, go directly to OWNED with the new grant next cycle; otherwise go to IDLE.
- Simultaneous `done` and timeout in the same cycle: treat as `done`, with no `timeout_err`.
- The same master may win again after TURNAROUND if it is the only requester.
- `enabled` falling while OWNED has no effect until release; after release, the block stays in IDLE.

## Timing
- Reset values: `grant`=0, `bus_busy`=0, `owner_id`=0, `timeout_err`=0, `timeout_id`=0, `rr_ptr`=NUM_REQ-1 (so requester 0 is searched first), state IDLE, counter 0.
- Reset asserted mid-ownership clears `grant` immediately, without waiting for a clock edge.
- Request-to-grant latency: 1 cycle from IDLE (req sampled at edge N, grant high after edge N+1 is not allowed; grant is high after edge N).
- Release: `done` sampled at edge N drops `grant` after edge N. The next owner is granted after edge N+1, giving a minimum gap of one idle cycle.
- Maximum unlocked hold: `MAX_HOLD` cycles of grant, then forced release.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `bus_arb_pkg`:
  - state enum `{IDLE, OWNED, TURNAROUND}`;
  - requester-index constants (`REQ_CTRL`=0, `REQ_IO`=1, `REQ_DBG`=2);
  - `clog2`-based id width function.
- Sub-module `rr_picker`: combinational circular priority encoder.
  - Inputs: `req`, `rr_ptr`, priority-enable.
  - Outputs: `valid`, winner index.
  - Instantiated once and reused in IDLE and TURNAROUND.
- Top level holds the FSM, hold counter, `rr_ptr` and output registers.

## Test plan
- Reset, then `req`=4'b0110 with `CTRL_PRIORITY`=1 → `grant`=4'b0010 one cycle later, `owner_id`=1. Then `done[1]` → one zero-grant cycle, then `grant`=4'b0100.
- `req`=4'b1111 held, each owner pulses `done` after 2 cycles → grant order 0, 0, 0, … (priority); repeat with `CTRL_PRIORITY`=0 → order 0, 1, 2, 3, 0 with a one-cycle gap each time.
- Owner 2 holds `req` with `lock` low, `MAX_HOLD`=8 → grant high for 8 cycles, then `timeout_err` pulse with `timeout_id`=2. With `lock[2]` high → no timeout after 20 cycles.
- `done[2]` on the same cycle the timeout would fire → release with `timeout_err`=0; `done[3]` from a non-owner → no effect.
- `reset` driven low mid-ownership between clock edges → `grant`=0 and `bus_busy`=0 immediately. After reset releases with `req`=4'b1000 → `grant`=4'b1000 one cycle later.
- `enabled`=0 with `req`=4'b0001 → `grant` stays 0. `enabled` dropped while owner 1 is active → owner 1 keeps its grant until `done`, then the block stays in IDLE.
